// File: rtl/nes_cpu_bus_ctrl.sv
// CPU-side memory subsystem: mirrored work RAM, IO window, SRAM, PRG ROM, wait states, registered read data.
// Define NES_OAM_DMA_EN to build the 0x4014 OAM DMA engine; otherwise dma_busy is tied low.
module nes_cpu_bus_ctrl #(
  parameter int RAM_AW    = 11,
  parameter int IO_AW     = 3,
  parameter int SRAM_AW   = 13,
  parameter int ROM_AW    = 15,
  parameter int SRAM_WAIT = 0,
  parameter int ROM_WAIT  = 0
) (
  input  logic             clk,
  input  logic             b_rst,
  input  logic [15:0]      cpu_addr_out,
  input  logic [7:0]       cpu_data_out,
  input  logic             ren,
  input  logic             wen,
  output logic [7:0]       cpu_data_in,
  output logic             rdy,
  output logic [IO_AW-1:0] io_addr,
  output logic [7:0]       io_wdata,
  output logic             io_wen,
  output logic             io_ren,
  input  logic [7:0]       io_rdata,
  output logic             bus_err,
  output logic             dma_busy
);

`ifdef NES_OAM_DMA_EN
  typedef enum logic [2:0] {IDLE, WAIT, IOACC, DMA_ALIGN, DMA_RD, DMA_WR} state_e;
`else
  typedef enum logic [1:0] {IDLE, WAIT, IOACC} state_e;
`endif

  typedef enum logic [2:0] {RG_RAM, RG_IO, RG_NONE, RG_SRAM, RG_ROM} region_e;

  logic [7:0] ram  [2**RAM_AW];
  logic [7:0] sram [2**SRAM_AW];
  logic [7:0] rom  [2**ROM_AW];

  state_e           state_q, state_d;
  logic [3:0]       waitCnt_q, waitCnt_d;
  logic [15:0]      accAddr_q, accAddr_d;
  logic             accRead_q, accRead_d;
  logic             pendRd_q, pendRd_d;
  logic [7:0]       dataIn_q, dataIn_d;
  logic [IO_AW-1:0] ioAddr_q, ioAddr_d;
  logic [7:0]       ioWdata_q, ioWdata_d;
  logic             ioWen_q, ioWen_d;
  logic             ioRen_q, ioRen_d;
  logic             busErr_q, busErr_d;
  logic             ramWe, sramWe;
  logic [15:0]      rdAddr;
  logic [7:0]       rdData;
`ifdef NES_OAM_DMA_EN
  logic [7:0]       dmaPage_q, dmaPage_d;
  logic [7:0]       dmaIdx_q, dmaIdx_d;
`endif

  function automatic region_e decode(input logic [15:0] a);
    region_e r;
    if (a[15]) begin
      r = RG_ROM;
    end else begin
      case (a[14:13])
        2'b00:   r = RG_RAM;
        2'b01:   r = RG_IO;
        2'b10:   r = RG_NONE;
        default: r = RG_SRAM;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] waitFor(input logic [15:0] a);
    logic [3:0] w;
    case (decode(a))
      RG_SRAM: w = 4'(SRAM_WAIT);
      RG_ROM:  w = 4'(ROM_WAIT);
      default: w = 4'd0;
    endcase
    return w;
  endfunction

  // The CPU read pipeline and DMA reads never overlap, so they share one read port.
`ifdef NES_OAM_DMA_EN
  assign rdAddr = (state_q == DMA_RD) ? {dmaPage_q, dmaIdx_q} : accAddr_q;
`else
  assign rdAddr = accAddr_q;
`endif

  always_comb begin
    case (decode(rdAddr))
      RG_RAM:  rdData = ram[rdAddr[RAM_AW-1:0]];
      RG_SRAM: rdData = sram[rdAddr[SRAM_AW-1:0]];
      RG_ROM:  rdData = rom[rdAddr[ROM_AW-1:0]];
      default: rdData = 8'h00;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    accAddr_d = accAddr_q;
    accRead_d = accRead_q;
    pendRd_d  = 1'b0;
    dataIn_d  = dataIn_q;
    ioAddr_d  = ioAddr_q;
    ioWdata_d = ioWdata_q;
    ioWen_d   = 1'b0;
    ioRen_d   = 1'b0;
    busErr_d  = 1'b0;
    ramWe     = 1'b0;
    sramWe    = 1'b0;
`ifdef NES_OAM_DMA_EN
    dmaPage_d = dmaPage_q;
    dmaIdx_d  = dmaIdx_q;
`endif
    if (pendRd_q) dataIn_d = rdData;

    case (state_q)
      IDLE: begin
        if (ren || wen) begin
          accAddr_d = cpu_addr_out;
          accRead_d = ren && !wen;
          busErr_d  = ren && wen;
          case (decode(cpu_addr_out))
            RG_RAM: begin
              ramWe    = wen;
              pendRd_d = !wen;
            end
            RG_SRAM: begin
              sramWe = wen;
              if (SRAM_WAIT == 0) begin
                pendRd_d = !wen;
              end else begin
                state_d   = WAIT;
                waitCnt_d = 4'(SRAM_WAIT);
              end
            end
            RG_ROM: begin
              if (wen) busErr_d = 1'b1;
              if (ROM_WAIT == 0) begin
                pendRd_d = !wen;
              end else begin
                state_d   = WAIT;
                waitCnt_d = 4'(ROM_WAIT);
              end
            end
            RG_IO: begin
              state_d  = IOACC;
              ioAddr_d = cpu_addr_out[IO_AW-1:0];
              if (wen) ioWdata_d = cpu_data_out;
              ioWen_d  = wen;
              ioRen_d  = !wen;
            end
            default: begin
`ifdef NES_OAM_DMA_EN
              if (wen && cpu_addr_out == 16'h4014) begin
                state_d   = DMA_ALIGN;
                dmaPage_d = cpu_data_out;
              end
`endif
            end
          endcase
        end
      end
      WAIT: begin
        if (waitCnt_q == 4'd1) begin
          state_d  = IDLE;
          pendRd_d = accRead_q;
        end else begin
          waitCnt_d = waitCnt_q - 4'd1;
        end
      end
      IOACC: begin
        state_d = IDLE;
        if (ioRen_q) dataIn_d = io_rdata;
      end
`ifdef NES_OAM_DMA_EN
      DMA_ALIGN: begin
        state_d   = DMA_RD;
        dmaIdx_d  = 8'd0;
        waitCnt_d = waitFor({dmaPage_q, 8'h00});
      end
      DMA_RD: begin
        if (waitCnt_q != 4'd0) begin
          waitCnt_d = waitCnt_q - 4'd1;
        end else begin
          state_d   = DMA_WR;
          ioWen_d   = 1'b1;
          ioAddr_d  = IO_AW'(4);
          ioWdata_d = rdData;
        end
      end
      DMA_WR: begin
        if (dmaIdx_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          state_d   = DMA_RD;
          dmaIdx_d  = dmaIdx_q + 8'd1;
          waitCnt_d = waitFor({dmaPage_q, dmaIdx_q + 8'd1});
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q   <= IDLE;
      waitCnt_q <= 4'd0;
      accAddr_q <= 16'h0000;
      accRead_q <= 1'b0;
      pendRd_q  <= 1'b0;
      dataIn_q  <= 8'h00;
      ioAddr_q  <= '0;
      ioWdata_q <= 8'h00;
      ioWen_q   <= 1'b0;
      ioRen_q   <= 1'b0;
      busErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      accAddr_q <= accAddr_d;
      accRead_q <= accRead_d;
      pendRd_q  <= pendRd_d;
      dataIn_q  <= dataIn_d;
      ioAddr_q  <= ioAddr_d;
      ioWdata_q <= ioWdata_d;
      ioWen_q   <= ioWen_d;
      ioRen_q   <= ioRen_d;
      busErr_q  <= busErr_d;
    end
  end

`ifdef NES_OAM_DMA_EN
  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      dmaPage_q <= 8'h00;
      dmaIdx_q  <= 8'h00;
    end else begin
      dmaPage_q <= dmaPage_d;
      dmaIdx_q  <= dmaIdx_d;
    end
  end

  assign dma_busy = (state_q == DMA_ALIGN) || (state_q == DMA_RD) || (state_q == DMA_WR);
`else
  assign dma_busy = 1'b0;
`endif

  // Arrays are deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (b_rst && ramWe)  ram[cpu_addr_out[RAM_AW-1:0]]   <= cpu_data_out;
    if (b_rst && sramWe) sram[cpu_addr_out[SRAM_AW-1:0]] <= cpu_data_out;
  end

  assign rdy         = (state_q == IDLE);
  assign cpu_data_in = dataIn_q;
  assign io_addr     = ioAddr_q;
  assign io_wdata    = ioWdata_q;
  assign io_wen      = ioWen_q;
  assign io_ren      = ioRen_q;
  assign bus_err     = busErr_q;

endmodule

// File: tb/tb_nes_cpu_bus_ctrl.sv
// Self-checking bench for nes_cpu_bus_ctrl: directed vector table, randomized traffic against a
// memory-map model, reset abort, and the OAM DMA sequence when NES_OAM_DMA_EN is defined.
module tb_nes_cpu_bus_ctrl;

  localparam int SRAM_W = 2;
  localparam int ROM_W  = 3;

  logic        clk = 1'b0;
  logic        b_rst;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWdata;
  logic        ren, wen;
  logic [7:0]  cpuDataIn;
  logic        rdy;
  logic [2:0]  ioAddr;
  logic [7:0]  ioWdata;
  logic        ioWen, ioRen;
  logic [7:0]  ioRdata;
  logic        busErr, dmaBusy;

  int nVec = 0;
  int nMis = 0;

  logic [7:0] ramM  [2048];
  logic [7:0] sramM [8192];
  logic [7:0] romM  [32768];
  logic [7:0] curData;

  logic [10:0] ramPool  [16];
  logic [12:0] sramPool [16];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        r;
    logic        w;
    logic [7:0]  ioD;
    logic [7:0]  expD;
    logic        expE;
  } vec_t;

  vec_t tbl [16];

  nes_cpu_bus_ctrl #(
    .RAM_AW(11), .IO_AW(3), .SRAM_AW(13), .ROM_AW(15),
    .SRAM_WAIT(SRAM_W), .ROM_WAIT(ROM_W)
  ) dut (
    .clk(clk), .b_rst(b_rst), .cpu_addr_out(cpuAddr), .cpu_data_out(cpuWdata),
    .ren(ren), .wen(wen), .cpu_data_in(cpuDataIn), .rdy(rdy), .io_addr(ioAddr),
    .io_wdata(ioWdata), .io_wen(ioWen), .io_ren(ioRen), .io_rdata(ioRdata),
    .bus_err(busErr), .dma_busy(dmaBusy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected read value from the memory map: RAM/SRAM/ROM arrays, IO returns the register data,
  // unmapped keeps the bus value.
  function automatic logic [7:0] modelRead(input logic [15:0] a, input logic [7:0] ioD);
    if (a < 16'h2000)      return ramM[a[10:0]];
    else if (a < 16'h4000) return ioD;
    else if (a < 16'h6000) return curData;
    else if (a < 16'h8000) return sramM[a[12:0]];
    else                   return romM[a[14:0]];
  endfunction

  // One complete CPU access; every cycle up to data-valid is compared against the timing rules.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic r,
                               input logic w, input logic [7:0] ioD, input logic [7:0] expD,
                               input logic expE);
    int  lowCycles;
    int  last;
    bit  isIo, isRead;
    isRead = r && !w;
    isIo   = (a >= 16'h2000) && (a < 16'h4000);
    if (a >= 16'h8000)      lowCycles = ROM_W;
    else if (a >= 16'h6000) lowCycles = SRAM_W;
    else if (isIo)          lowCycles = 1;
    else                    lowCycles = 0;
    last = isIo ? 1 : lowCycles + 1;
    @(negedge clk);
    cpuAddr = a; cpuWdata = d; ren = r; wen = w; ioRdata = ioD;
    @(posedge clk);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) begin ren = 1'b0; wen = 1'b0; end
      checkOutput("rdy", 16'(rdy), 16'(k >= lowCycles));
      checkOutput("bus_err", 16'(busErr), 16'(k == 0 && expE));
      checkOutput("io_wen", 16'(ioWen), 16'(k == 0 && isIo && w));
      checkOutput("io_ren", 16'(ioRen), 16'(k == 0 && isIo && isRead));
      checkOutput("dma_busy", 16'(dmaBusy), 16'h0);
      if (k == 0 && isIo) begin
        checkOutput("io_addr", 16'(ioAddr), 16'(a[2:0]));
        if (w) checkOutput("io_wdata", 16'(ioWdata), 16'(d));
      end
      checkOutput("cpu_data_in", 16'(cpuDataIn), 16'((isRead && k >= last) ? expD : curData));
    end
    if (isRead) curData = expD;
    if (w && a < 16'h2000) ramM[a[10:0]] = d;
    if (w && a >= 16'h6000 && a < 16'h8000) sramM[a[12:0]] = d;
  endtask

  task automatic randomAccess();
    logic [15:0] a;
    logic [7:0]  d, ioD;
    logic        r, w;
    int          sel;
    int          idx;
    d   = 8'($urandom);
    ioD = 8'($urandom);
    sel = $urandom_range(0, 7);
    r   = (sel == 0) || (sel >= 4);
    w   = (sel <= 3);
    idx = $urandom_range(0, 15);
    case ($urandom_range(0, 4))
      0:       a = {3'b000, 2'($urandom_range(0, 3)), ramPool[idx]};
      1:       a = {3'b011, sramPool[idx]};
      2:       a = 16'h8000 | 16'($urandom_range(0, 32767));
      3:       a = 16'h2000 | 16'($urandom_range(0, 8191));
      default: a = 16'h4000 | 16'($urandom_range(0, 8191));
    endcase
`ifdef NES_OAM_DMA_EN
    if (w && a == 16'h4014) a = 16'h4015;
`endif
    applyStimulus(a, d, r, w, ioD, (r && !w) ? modelRead(a, ioD) : curData,
                  (r && w) || (w && a >= 16'h8000));
  endtask

`ifdef NES_OAM_DMA_EN
  // Starts a DMA from page p; abortAt >= 0 pulses reset on that cycle after the accept edge.
  task automatic runDma(input logic [7:0] p, input int abortAt);
    int lowCnt = 0;
    int pulses = 0;
    bit done   = 1'b0;
    @(negedge clk);
    cpuAddr = 16'h4014; cpuWdata = p; wen = 1'b1; ren = 1'b0;
    @(posedge clk);
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      wen = 1'b0;
      if (cyc == abortAt) begin
        b_rst = 1'b0;
        #1;
        checkOutput("abort_rdy", 16'(rdy), 16'h1);
        checkOutput("abort_dma_busy", 16'(dmaBusy), 16'h0);
        checkOutput("abort_io_wen", 16'(ioWen), 16'h0);
        @(negedge clk);
        b_rst = 1'b1;
        pulses = 0;
        for (int j = 0; j < 600; j++) begin
          @(negedge clk);
          if (ioWen) pulses++;
        end
        checkOutput("abort_late_io_wen", 16'(pulses), 16'h0);
        curData = 8'h00;
        return;
      end
      if (rdy) begin
        done = 1'b1;
      end else begin
        lowCnt++;
        if (!dmaBusy) checkOutput("dma_busy_hi", 16'(dmaBusy), 16'h1);
        if (ioWen) begin
          checkOutput("dma_io_addr", 16'(ioAddr), 16'h4);
          checkOutput("dma_io_wdata", 16'(ioWdata), 16'(modelRead({p, 8'(pulses)}, 8'h00)));
          pulses++;
        end
      end
    end
    checkOutput("dma_finished", 16'(done), 16'h1);
    checkOutput("dma_rdy_low_cycles", 16'(lowCnt), 16'd513);
    checkOutput("dma_pulses", 16'(pulses), 16'd256);
  endtask
`endif

  initial begin
    b_rst = 1'b0; cpuAddr = 16'h0; cpuWdata = 8'h0; ren = 1'b0; wen = 1'b0; ioRdata = 8'h0;
    curData = 8'h00;
    for (int i = 0; i < 32768; i++) begin
      romM[i] = 8'($urandom);
      if (i == 0)      romM[i] = 8'h5A;
      if (i == 15'h7FFC) romM[i] = 8'h34;
      dut.rom[i] = romM[i];
    end
    for (int i = 0; i < 16; i++) begin
      ramPool[i]  = 11'((i * 137) % 2048);
      sramPool[i] = 13'((i * 523 + 1) % 8192);
    end

    tbl[0]  = '{16'h0012, 8'hA5, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{16'h0812, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[2]  = '{16'h1812, 8'h00, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    tbl[3]  = '{16'hFFFC, 8'h00, 1'b1, 1'b0, 8'h00, 8'h34, 1'b0};
    tbl[4]  = '{16'h8000, 8'h99, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[5]  = '{16'h8000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h5A, 1'b0};
    tbl[6]  = '{16'h0005, 8'h77, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1};
    tbl[7]  = '{16'h0005, 8'h00, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0};
    tbl[8]  = '{16'h3FF8, 8'h80, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{16'h2002, 8'h00, 1'b1, 1'b0, 8'h9F, 8'h9F, 1'b0};
    tbl[10] = '{16'h0000, 8'h11, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[11] = '{16'h0000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0};
    tbl[12] = '{16'h5000, 8'h00, 1'b1, 1'b0, 8'h00, 8'h11, 1'b0};
    tbl[13] = '{16'h7FFF, 8'hC3, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
    tbl[14] = '{16'h7FFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0};
    tbl[15] = '{16'h4014, 8'h00, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0};

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_rdy", 16'(rdy), 16'h1);
    checkOutput("reset_cpu_data_in", 16'(cpuDataIn), 16'h0);
    checkOutput("reset_io_addr", 16'(ioAddr), 16'h0);
    checkOutput("reset_io_wdata", 16'(ioWdata), 16'h0);
    checkOutput("reset_io_wen", 16'(ioWen), 16'h0);
    checkOutput("reset_io_ren", 16'(ioRen), 16'h0);
    checkOutput("reset_bus_err", 16'(busErr), 16'h0);
    checkOutput("reset_dma_busy", 16'(dmaBusy), 16'h0);
    b_rst = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++)
      applyStimulus(tbl[i].addr, tbl[i].wdata, tbl[i].r, tbl[i].w, tbl[i].ioD, tbl[i].expD,
                    tbl[i].expE);
    checkOutput("rom_unchanged", 16'(dut.rom[0]), 16'h5A);

    // Without the DMA engine, 0x4014 is unmapped and the write is simply dropped.
`ifndef NES_OAM_DMA_EN
    applyStimulus(16'h4014, 8'h02, 1'b0, 1'b1, 8'h00, curData, 1'b0);
`endif

    $display("[TB] randomized traffic");
    for (int i = 0; i < 16; i++) begin
      applyStimulus({5'b00000, ramPool[i]}, 8'($urandom), 1'b0, 1'b1, 8'h00, curData, 1'b0);
      applyStimulus({3'b011, sramPool[i]}, 8'($urandom), 1'b0, 1'b1, 8'h00, curData, 1'b0);
    end
    for (int i = 0; i < 150; i++) randomAccess();

    $display("[TB] reset during a ROM wait");
    @(negedge clk);
    cpuAddr = 16'hFFFC; ren = 1'b1; wen = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ren = 1'b0;
    @(negedge clk);
    checkOutput("wait_rdy_low", 16'(rdy), 16'h0);
    b_rst = 1'b0;
    #1;
    checkOutput("midreset_rdy", 16'(rdy), 16'h1);
    checkOutput("midreset_data", 16'(cpuDataIn), 16'h0);
    @(negedge clk);
    b_rst = 1'b1;
    curData = 8'h00;
    for (int j = 0; j < 6; j++) @(negedge clk);
    checkOutput("aborted_read_data", 16'(cpuDataIn), 16'h0);
    checkOutput("aborted_read_rdy", 16'(rdy), 16'h1);
    applyStimulus(16'h1012, 8'h00, 1'b1, 1'b0, 8'h00, ramM[11'h012], 1'b0);

`ifdef NES_OAM_DMA_EN
    $display("[TB] OAM DMA");
    for (int i = 0; i < 256; i++)
      applyStimulus(16'h0200 + 16'(i), 8'(i), 1'b0, 1'b1, 8'h00, curData, 1'b0);
    runDma(8'h02, -1);
    runDma(8'h02, 100);
    applyStimulus(16'h0A05, 8'h00, 1'b1, 1'b0, 8'h00, 8'h05, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
